// File: rtl/iir_tdm_sched.sv
// Time-multiplexed first-order IIR filter: NCH channels share one 16x18 multiplier.
// A round-robin scheduler picks one channel per IDLE visit. The sample is then run
// through three MAC steps and an OUT step, so one result is produced every 5 cycles.
module iir_tdm_sched #(
  parameter int unsigned        NCH     = 4,
  parameter logic signed [17:0] coef_b0 = 18'sd131070,
  parameter logic signed [17:0] coef_b1 = -18'sd123584,
  parameter logic signed [17:0] coef_a1 = 18'sd22500
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NCH-1:0]          req_i,
  input  logic [16*NCH-1:0]       data_i,
  output logic [NCH-1:0]          ack_o,
  output logic                    busy_o,
  output logic                    out_valid_o,
  output logic [$clog2(NCH)-1:0]  out_chan_o,
  output logic [15:0]             data_o
);

  localparam int unsigned CW = $clog2(NCH);

  localparam logic signed [17:0] ACC_MAX = 18'sh1FFFF;
  localparam logic signed [17:0] ACC_MIN = 18'sh20000;
  localparam logic signed [15:0] OUT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] OUT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAC0 = 3'd1,
    S_MAC1 = 3'd2,
    S_MAC2 = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      chan_q;
  logic signed [15:0] x_q;
  logic signed [17:0] acc_q;
  logic signed [15:0] x1_q [NCH];
  logic signed [15:0] y1_q [NCH];

  logic               gnt_found_c;
  logic [CW-1:0]      gnt_idx_c;
  logic [15:0]        gnt_data_c;
  logic signed [15:0] mul_a_c;
  logic signed [17:0] mul_b_c;
  logic signed [33:0] prod_c;
  logic signed [18:0] term_c;
  logic signed [18:0] sum_c;
  logic signed [15:0] acc_sat16_c;

  // Clamp a 19-bit sum to the 18-bit accumulator range
  function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
    if (v > 19'(ACC_MAX))      return ACC_MAX;
    else if (v < 19'(ACC_MIN)) return ACC_MIN;
    else                       return v[17:0];
  endfunction

  // Clamp the accumulator to the 16-bit output range
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > 18'(OUT_MAX))      return OUT_MAX;
    else if (v < 18'(OUT_MIN)) return OUT_MIN;
    else                       return v[15:0];
  endfunction

  // Round-robin grant search starting after the last-granted channel, plus next-state logic
  always_comb begin
    int unsigned j;
    state_d     = state_q;
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    gnt_data_c  = '0;
    j           = 0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      j = 32'(chan_q) + i;
      if (j >= NCH) j = j - NCH;
      if (!gnt_found_c && req_i[CW'(j)]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = CW'(j);
        gnt_data_c  = data_i[j*16 +: 16];
      end
    end
    case (state_q)
      S_IDLE:  if (gnt_found_c) state_d = S_MAC0;
      S_MAC0:  state_d = S_MAC1;
      S_MAC1:  state_d = S_MAC2;
      S_MAC2:  state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shared multiplier operand select, product scaling and accumulate
  always_comb begin
    mul_a_c = x_q;
    mul_b_c = coef_b0;
    case (state_q)
      S_MAC1: begin
        mul_a_c = x1_q[chan_q];
        mul_b_c = coef_b1;
      end
      S_MAC2: begin
        mul_a_c = y1_q[chan_q];
        mul_b_c = coef_a1;
      end
      default: ;
    endcase
    prod_c      = 34'(mul_a_c) * 34'(mul_b_c);
    term_c      = 19'(prod_c >>> 15);
    sum_c       = 19'(acc_q) + term_c;
    acc_sat16_c = sat16(acc_q);
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath, channel history and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      chan_q      <= CW'(NCH - 1);
      x_q         <= '0;
      acc_q       <= '0;
      ack_o       <= '0;
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
      out_chan_o  <= '0;
      data_o      <= '0;
      for (int k = 0; k < int'(NCH); k++) begin
        x1_q[k] <= '0;
        y1_q[k] <= '0;
      end
    end else begin
      ack_o       <= '0;
      out_valid_o <= 1'b0;
      busy_o      <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (gnt_found_c) begin
            chan_q <= gnt_idx_c;
            x_q    <= gnt_data_c;
            ack_o  <= NCH'(1) << gnt_idx_c;
          end
        end
        S_MAC0: acc_q <= sat18(term_c);
        S_MAC1: acc_q <= sat18(sum_c);
        S_MAC2: acc_q <= sat18(sum_c);
        S_OUT: begin
          data_o       <= acc_sat16_c;
          out_chan_o   <= chan_q;
          out_valid_o  <= 1'b1;
          x1_q[chan_q] <= x_q;
          y1_q[chan_q] <= acc_sat16_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_tdm_sched.sv
// Scoreboard bench for iir_tdm_sched: stimulus pushes expected acks/results, monitor checks.
module tb_iir_tdm_sched;

  localparam int NCH = 4;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [NCH-1:0]    req_i;
  logic [16*NCH-1:0] data_i;
  logic [NCH-1:0]    ack_o;
  logic              busy_o;
  logic              out_valid_o;
  logic [1:0]        out_chan_o;
  logic [15:0]       data_o;

  iir_tdm_sched #(.NCH(NCH)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_i       (req_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_chan_o  (out_chan_o),
    .data_o      (data_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int exp_ack_q[$];
  int exp_chan_q[$];
  int exp_data_q[$];
  int ack_t_q[$];

  int ack_cnt   = 0;
  int valid_cnt = 0;
  bit chk_spacing = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares acks, results, latency and back-to-back spacing
  initial begin
    bit have_last = 1'b0;
    int last_ack  = 0;
    bit busy_p1   = 1'b0;
    bit busy_p2   = 1'b0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        have_last = 1'b0;
        ack_t_q.delete();
      end else begin
        if (ack_o != '0) begin
          ack_cnt++;
          if (exp_ack_q.size() == 0) chk("ack_unexpected", int'(ack_o), 0);
          else                       chk("ack_onehot", int'(ack_o), exp_ack_q.pop_front());
          if (chk_spacing && have_last) begin
            chk("ack_spacing", cyc - last_ack, 5);
            chk("busy_gap_low", int'(busy_p1), 0);
            chk("busy_before_gap", int'(busy_p2), 1);
          end
          have_last = 1'b1;
          last_ack  = cyc;
          ack_t_q.push_back(cyc);
        end
        if (out_valid_o) begin
          valid_cnt++;
          if (exp_chan_q.size() == 0) begin
            chk("out_valid_unexpected", 1, 0);
          end else begin
            chk("out_chan", int'(out_chan_o), exp_chan_q.pop_front());
            chk("data_o", int'($signed(data_o)), exp_data_q.pop_front());
          end
          if (ack_t_q.size() != 0) chk("latency", cyc - ack_t_q.pop_front(), 4);
        end
      end
      busy_p2 = busy_p1;
      busy_p1 = busy_o;
    end
  end

  task automatic do_reset();
    req_i   = '0;
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_ack", int'(ack_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_valid", int'(out_valid_o), 0);
    chk("rst_chan", int'(out_chan_o), 0);
    chk("rst_data", int'(data_o), 0);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic set_data(input int ch, input int val);
    data_i[ch*16 +: 16] = 16'(val);
  endtask

  task automatic expect_out(input int ch, input int val);
    exp_chan_q.push_back(ch);
    exp_data_q.push_back(val);
  endtask

  // Request one sample on one channel and hold until its ack is seen
  task automatic send(input int ch, input int val, input bit want_out, input int exp_val);
    bit got = 1'b0;
    set_data(ch, val);
    exp_ack_q.push_back(1 << ch);
    if (want_out) expect_out(ch, exp_val);
    req_i[ch] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (ack_o[ch]) begin
        got = 1'b1;
        break;
      end
    end
    req_i[ch] = 1'b0;
    if (!got) chk("ack_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_chan_q.size() != 0 && n < 60) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_left", exp_chan_q.size(), 0);
    @(negedge clk_i);
  endtask

  task automatic wait_acks(input int target);
    int n = 0;
    while (ack_cnt < target && n < 80) begin
      @(negedge clk_i);
      n++;
    end
    chk("ack_count", ack_cnt, target);
  endtask

  initial begin
    int base;
    int vbefore;
    reset_i = 1'b1;
    req_i   = '0;
    data_i  = '0;
    @(negedge clk_i);
    do_reset();

    // ch0 100 -> 399, then ch0 0 -> -105 using history
    send(0, 100, 1'b1, 399);
    drain();
    send(0, 0, 1'b1, -105);
    drain();

    // ch2 full-scale saturates high, then negative saturation from history; ch0 untouched
    do_reset();
    send(2, 32767, 1'b1, 32767);
    drain();
    send(2, 0, 1'b1, -32768);
    drain();
    send(0, 100, 1'b1, 399);
    drain();

    // req 1010 held: ch1 then ch3 five cycles later
    do_reset();
    chk_spacing = 1'b1;
    set_data(1, 100);
    set_data(3, -100);
    exp_ack_q.push_back(2);
    exp_ack_q.push_back(8);
    expect_out(1, 399);
    expect_out(3, -400);
    base  = ack_cnt;
    req_i = 4'b1010;
    wait_acks(base + 2);
    req_i = '0;
    drain();

    // all four channels requesting: two full rotations
    do_reset();
    set_data(0, 100);
    set_data(1, -100);
    set_data(2, 0);
    set_data(3, 100);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) exp_ack_q.push_back(1 << c);
    expect_out(0, 399);
    expect_out(1, -400);
    expect_out(2, 0);
    expect_out(3, 399);
    expect_out(0, 294);
    expect_out(1, -298);
    expect_out(2, 0);
    expect_out(3, 294);
    base  = ack_cnt;
    req_i = 4'b1111;
    wait_acks(base + 8);
    req_i = '0;
    drain();
    chk_spacing = 1'b0;

    // reset during MAC1 aborts the sample; history stays clear
    do_reset();
    vbefore = valid_cnt;
    send(0, 100, 1'b0, 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    repeat (8) @(negedge clk_i);
    chk("abort_no_valid", valid_cnt, vbefore);
    send(0, 100, 1'b1, 399);
    drain();

    chk("ack_queue_empty", exp_ack_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
